uart_tx_port: RTL and testbench
===============================

# uart_tx_port

Memory-mapped UART transmitter that responds to the CPU's single-cycle bus writes and reads. CPU stores to the data register queue a byte; a serializer shifts it out as 8N1 frames on `tx`. Status is readable on the same bus, so firmware can poll for space instead of relying on the bench printing bytes written to 0xF010. The block sits beside `Memory`, with read data muxed in by address select.

## Interface
- `BASE_ADDR`, 16'hF010: address of the TXDATA register. STATUS is at `BASE_ADDR+1`.
- `CLKS_PER_BIT`, 16: clocks per serial bit. Must be ≥2.
- `FIFO_DEPTH`, 8: FIFO entries, power of two. Used only when the FIFO is compiled in.

Ports:
- `clock`  in  1: single clock; all state updates on posedge.
- `reset`  in  1: asynchronous, active-high.
- `address`  in  16: CPU bus address.
- `write_en`  in  1: CPU write strobe. A write takes effect at the posedge.
- `data_in`  in  8: CPU write data.
- `data_out`  out  8: read data. Combinational; 0 unless a read hits.
- `sel`  out  1: combinational; high when `address` is `BASE_ADDR` or `BASE_ADDR+1`.
- `tx`  out  1: serial line; idles high.

## Operation
Register map:
- **TXDATA (`BASE_ADDR`)**
  - Write pushes `data_in[7:0]` into the FIFO.
  - Read returns 0.
- **STATUS (`BASE_ADDR+1`)**
  - Read bits: [0] busy (serializer not IDLE), [1] full, [2] empty, [7] overflow (sticky). Other bits read 0.
  - Any write clears overflow.
- Reads are combinational: `data_out` = STATUS when `sel && !write_en && address==BASE_ADDR+1`; otherwise 0.

Push rules:
- A push when the FIFO is full is dropped and sets overflow.
- A push in the same cycle the serializer pops is accepted, even if the FIFO was full. The count is unchanged.

Serializer FSM: IDLE → START → DATA → STOP.
- **IDLE:** `tx`=1. If the FIFO is not empty, pop into the shift register, clear the bit counter and baud counter, and go to START.
- **START:** `tx`=0 for `CLKS_PER_BIT` clocks, then go to DATA.
- **DATA:** `tx`=shift[0], LSB first. Each bit lasts `CLKS_PER_BIT` clocks. After bit 7, go to STOP.
- **STOP:** `tx`=1 for `CLKS_PER_BIT` clocks.
  - On the last STOP clock, if the FIFO is not empty, pop and go directly to START. No idle gap.
  - Otherwise go to IDLE.
- Baud counter counts 0..`CLKS_PER_BIT-1`. The bit counter is 3 bits.

Reset:
- `tx`=1, FSM in IDLE, FIFO empty, overflow=0, all counters 0.
- Reset mid-frame aborts the frame immediately. `tx` returns high asynchronously and queued bytes are lost.

## Timing
- A push at posedge N makes empty=0 visible after N. The serializer pops at posedge N+1. The `tx` falling edge is registered at posedge N+1.
- A frame is exactly `10*CLKS_PER_BIT` clocks. `tx` is a registered output with no glitches.
- busy rises with the pop edge. It falls at the end of STOP only when the FIFO is empty.
- A write to STATUS and a push in the same cycle cannot occur; these are distinct addresses.
- An overflow set and an overflow clear cannot collide, for the same reason.

## Configuration
- **`UART_TX_FIFO_EN` defined:** a FIFO of `FIFO_DEPTH` entries with wrap-around read and write pointers, plus a count of width log2(`FIFO_DEPTH`)+1.
- **Not defined:** a single holding register.
  - full = holding register valid; empty = !valid.
  - A push while valid is dropped and sets overflow, unless a pop occurs the same cycle.
  - `FIFO_DEPTH` is ignored.

## Structure
- Shared package `uart_defs` holds:
  - the STATUS bit indices (`ST_BUSY`=0, `ST_FULL`=1, `ST_EMPTY`=2, `ST_OVF`=7);
  - the FSM state encoding (IDLE, START, DATA, STOP);
  - the register offsets (TXDATA=0, STATUS=1).
- Sub-module `uart_tx_fifo` has push/pop/full/empty/count ports and wraps the depth-1 or depth-N storage selected by `UART_TX_FIFO_EN`.
- The top level holds address decode, STATUS, and the serializer FSM.

## Test plan
All scenarios use `CLKS_PER_BIT`=4 and `FIFO_DEPTH`=4.
1. **Reset:** assert `reset` mid-frame → `tx`=1 immediately, and STATUS reads 8'h04.
2. **Single byte:** write 8'h41 to 0xF010 → `tx` falls 1 clock later. The 40-clock frame is 0,1,0,0,0,0,0,1,0,1, each bit held 4 clocks. busy=1 throughout; STATUS returns to 8'h04 afterwards.
3. **Back-to-back:** write 8'h48 then 8'h69 on consecutive clocks → two frames with no idle clock between them, 80 clocks total.
4. **Overflow:** with the FIFO enabled, write 6 bytes on 6 consecutive clocks.
   - Bytes 1–5 are accepted: the first is popped into the serializer, the next 4 fill the FIFO.
   - The 6th is dropped.
   - STATUS reads 8'h83.
   - A write to 0xF011 → STATUS reads 8'h03.
5. **Full plus pop:** fill the FIFO, then push on the exact clock of the STOP→START pop → push accepted, full stays 1, overflow stays 0.
6. **Decode:** reads at 0xF012 and 0xF00F → `sel`=0 and `data_out`=0. A read at 0xF010 → `sel`=1 and `data_out`=0.

Source files
------------

// File: rtl/uart_tx_port_pkg.sv
// Shared definitions for the memory-mapped UART transmitter:
// STATUS bit positions, register offsets and serializer state encoding.
package uart_defs;

    localparam int unsigned ST_BUSY  = 0;
    localparam int unsigned ST_FULL  = 1;
    localparam int unsigned ST_EMPTY = 2;
    localparam int unsigned ST_OVF   = 7;

    localparam logic [15:0] REG_TXDATA = 16'd0;
    localparam logic [15:0] REG_STATUS = 16'd1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

endpackage

// File: rtl/uart_tx_port_fifo.sv
// Transmit byte storage for uart_tx_port.
// With UART_TX_FIFO_EN defined: FIFO_DEPTH-entry ring buffer (power of two).
// Otherwise: a single holding register; FIFO_DEPTH only sizes the count port.
// A push while full is accepted only if a pop happens in the same cycle.
module uart_tx_fifo
    import uart_defs::*;
#(
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          push,
    input  logic [7:0]                    wr_data,
    input  logic                          pop,
    output logic [7:0]                    rd_data,
    output logic                          full,
    output logic                          empty,
    output logic [$clog2(FIFO_DEPTH):0]   count
);

`ifdef UART_TX_FIFO_EN
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = FIFO_DEPTH[PTR_W:0];

    logic [7:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W:0]   cnt;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop && (cnt != '0);
    assign do_push = push && ((cnt != FULL_CNT) || do_pop);
    assign full    = (cnt == FULL_CNT);
    assign empty   = (cnt == '0);
    assign count   = cnt;
    assign rd_data = mem[rd_ptr];

    // Storage array; contents need no reset since count gates every read.
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Wrap-around pointers and occupancy count.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end
`else
    logic [7:0] hold;
    logic       valid;

    assign full    = valid;
    assign empty   = !valid;
    assign rd_data = hold;

    // Count port is 0 or 1 in this configuration.
    always_comb begin
        count    = '0;
        count[0] = valid;
    end

    // Single holding register; a push alongside a pop refills it in place.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hold  <= '0;
            valid <= 1'b0;
        end else if (push && (!valid || pop)) begin
            hold  <= wr_data;
            valid <= 1'b1;
        end else if (pop) begin
            valid <= 1'b0;
        end
    end
`endif

endmodule

// File: rtl/uart_tx_port.sv
// Memory-mapped 8N1 UART transmitter: TXDATA at BASE_ADDR, STATUS at BASE_ADDR+1.
// Define UART_TX_FIFO_EN to replace the single holding register with a
// FIFO_DEPTH-entry FIFO. Reads are combinational; tx is registered.
module uart_tx_port
    import uart_defs::*;
#(
    parameter logic [15:0] BASE_ADDR    = 16'hF010,
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned FIFO_DEPTH   = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] address,
    input  logic        write_en,
    input  logic [7:0]  data_in,
    output logic [7:0]  data_out,
    output logic        sel,
    output logic        tx
);

    localparam int unsigned BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

    tx_state_t                     state;
    logic [7:0]                    shift;
    logic [2:0]                    bit_cnt;
    logic [BAUD_W-1:0]             baud;
    logic                          overflow;

    logic                          hit_data;
    logic                          hit_status;
    logic                          push;
    logic                          pop;
    logic                          baud_done;
    logic [7:0]                    fifo_rd;
    logic                          fifo_full;
    logic                          fifo_empty;
    logic [$clog2(FIFO_DEPTH):0]   fifo_count;
    logic [7:0]                    status;

    assign hit_data   = (address == BASE_ADDR + REG_TXDATA);
    assign hit_status = (address == BASE_ADDR + REG_STATUS);
    assign sel        = hit_data || hit_status;
    assign push       = write_en && hit_data;
    assign baud_done  = (baud == BAUD_LAST);
    // Pop from IDLE, or on the last STOP clock so frames run back-to-back.
    assign pop        = !fifo_empty && ((state == IDLE) || ((state == STOP) && baud_done));

    uart_tx_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .push    (push),
        .wr_data (data_in),
        .pop     (pop),
        .rd_data (fifo_rd),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    // STATUS register image and combinational read mux.
    always_comb begin
        status           = '0;
        status[ST_BUSY]  = (state != IDLE);
        status[ST_FULL]  = fifo_full;
        status[ST_EMPTY] = (fifo_count == '0);
        status[ST_OVF]   = overflow;
        data_out         = (hit_status && !write_en) ? status : '0;
    end

    // Sticky overflow: set by a dropped push, cleared by any STATUS write.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            overflow <= 1'b0;
        end else if (write_en && hit_status) begin
            overflow <= 1'b0;
        end else if (push && fifo_full && !pop) begin
            overflow <= 1'b1;
        end
    end

    // Serializer FSM: start bit, 8 data bits LSB first, stop bit.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            tx      <= 1'b1;
            shift   <= '0;
            bit_cnt <= '0;
            baud    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    tx <= 1'b1;
                    if (pop) begin
                        shift   <= fifo_rd;
                        bit_cnt <= '0;
                        baud    <= '0;
                        tx      <= 1'b0;
                        state   <= START;
                    end
                end
                START: begin
                    if (baud_done) begin
                        baud  <= '0;
                        tx    <= shift[0];
                        state <= DATA;
                    end else begin
                        baud <= baud + 1'b1;
                    end
                end
                DATA: begin
                    if (baud_done) begin
                        baud <= '0;
                        if (bit_cnt == 3'd7) begin
                            tx    <= 1'b1;
                            state <= STOP;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                            shift   <= shift >> 1;
                            tx      <= shift[1];
                        end
                    end else begin
                        baud <= baud + 1'b1;
                    end
                end
                STOP: begin
                    if (baud_done) begin
                        baud <= '0;
                        if (pop) begin
                            shift   <= fifo_rd;
                            bit_cnt <= '0;
                            tx      <= 1'b0;
                            state   <= START;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        baud <= baud + 1'b1;
                    end
                end
                default: begin
                    tx    <= 1'b1;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_port.sv
// Bench for uart_tx_port with CLKS_PER_BIT=4, FIFO_DEPTH=4.
// Expected bytes are queued when written; a line monitor decodes frames on tx
// and checks them against the queue. Works with or without UART_TX_FIFO_EN.
module tb_uart_tx_port;

    localparam int CPB   = 4;
    localparam int FRAME = 10 * CPB;
`ifdef UART_TX_FIFO_EN
    localparam int CAP = 5;   // one byte in the serializer plus four queued
`else
    localparam int CAP = 2;   // one byte in the serializer plus the holding register
`endif

    logic        clock = 1'b0;
    logic        reset;
    logic [15:0] address;
    logic        write_en;
    logic [7:0]  data_in;
    logic [7:0]  data_out;
    logic        sel;
    logic        tx;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic [7:0]  exp_q[$];
    int          start_cyc[$];
    logic [FRAME-1:0] mon_s;
    logic [FRAME-1:0] mon_e;
    logic [9:0]  mon_fb;
    logic [7:0]  mon_got;
    logic [7:0]  mon_exp;
    logic        mon_abort;

    uart_tx_port #(
        .BASE_ADDR    (16'hF010),
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (4)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .address  (address),
        .write_en (write_en),
        .data_in  (data_in),
        .data_out (data_out),
        .sel      (sel),
        .tx       (tx)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic wr(input logic [15:0] a, input logic [7:0] d);
        address  = a;
        data_in  = d;
        write_en = 1'b1;
        @(negedge clock);
    endtask

    task automatic bus_idle();
        write_en = 1'b0;
        address  = 16'h0000;
    endtask

    task automatic read_status(output logic [7:0] v);
        write_en = 1'b0;
        address  = 16'hF011;
        #1;
        v = data_out;
    endtask

    task automatic wait_idle(input string name, input int budget);
        logic [7:0] v;
        int n;
        n = 0;
        read_status(v);
        while (v !== 8'h04 && n < budget) begin
            @(negedge clock);
            read_status(v);
            n++;
        end
        check(name, v, 8'h04);
    endtask

    // Line monitor: sample tx on every negedge of a frame and compare.
    initial begin
        forever begin
            @(negedge clock);
            if (!reset && tx === 1'b0) begin
                start_cyc.push_back(cyc);
                mon_abort = 1'b0;
                mon_s[0]  = tx;
                for (int j = 1; j < FRAME; j++) begin
                    @(negedge clock);
                    if (reset) begin
                        mon_abort = 1'b1;
                        break;
                    end
                    mon_s[j] = tx;
                end
                if (!mon_abort) begin
                    for (int i = 0; i < 8; i++) mon_got[i] = mon_s[CPB * (i + 1) + 2];
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL frame: got unexpected byte %02h expected no frame", mon_got);
                    end else begin
                        mon_exp = exp_q.pop_front();
                        mon_fb  = {1'b1, mon_exp, 1'b0};
                        for (int j = 0; j < FRAME; j++) mon_e[j] = mon_fb[j / CPB];
                        if (mon_s !== mon_e) begin
                            errors++;
                            $display("FAIL frame: got byte %02h line %h expected byte %02h line %h",
                                     mon_got, mon_s, mon_exp, mon_e);
                        end
                    end
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        logic [7:0] v;
        int bad;
        int n;
        int c0;

        reset    = 1'b0;
        write_en = 1'b0;
        address  = 16'h0000;
        data_in  = 8'h00;
        #2 reset = 1'b1;
        #1;
        check("reset_tx", tx, 1'b1);
        read_status(v);
        check("reset_status", v, 8'h04);
        repeat (2) @(negedge clock);
        reset = 1'b0;

        // Single byte: tx falls one clock after the push, busy for 40 clocks.
        @(negedge clock);
        exp_q.push_back(8'h41);
        wr(16'hF010, 8'h41);
        bus_idle();
        check("tx_before_pop", tx, 1'b1);
        @(negedge clock);
        check("tx_fall", tx, 1'b0);
        bad = 0;
        for (int j = 0; j < FRAME; j++) begin
            read_status(v);
            if (v[0] !== 1'b1) bad++;
            @(negedge clock);
        end
        check("busy_frame_lapses", bad, 0);
        read_status(v);
        check("single_end_status", v, 8'h04);

        // Back-to-back: second frame starts exactly 40 clocks after the first.
        @(negedge clock);
        start_cyc.delete();
        exp_q.push_back(8'h48);
        exp_q.push_back(8'h69);
        wr(16'hF010, 8'h48);
        wr(16'hF010, 8'h69);
        bus_idle();
        n = 0;
        while (start_cyc.size() < 2 && n < 200) begin
            @(negedge clock);
            #1;
            n++;
        end
        check("b2b_two_starts", start_cyc.size(), 2);
        if (start_cyc.size() >= 2) begin
            check("b2b_gap", start_cyc[1] - start_cyc[0], FRAME);
            c0 = start_cyc[0];
            n = 0;
            while (cyc != c0 + 2 * FRAME - 1 && n < 200) begin
                @(negedge clock);
                n++;
            end
            read_status(v);
            check("b2b_busy_last", v[0], 1'b1);
            @(negedge clock);
            read_status(v);
            check("b2b_end_status", v, 8'h04);
        end

        // Overflow: six consecutive pushes, the sixth is dropped.
        wait_idle("pre_ovf_idle", 300);
        @(negedge clock);
        for (int k = 0; k < 6; k++) begin
            if (k < CAP) exp_q.push_back(8'hA0 + 8'(k));
            wr(16'hF010, 8'hA0 + 8'(k));
        end
        bus_idle();
        read_status(v);
        check("ovf_status", v, 8'h83);
        @(negedge clock);
        wr(16'hF011, 8'h00);
        bus_idle();
        read_status(v);
        check("ovf_cleared", v, 8'h03);
        wait_idle("ovf_drain", CAP * FRAME + 100);

        // Full plus pop: push on the STOP->START pop edge of the first frame.
        @(negedge clock);
        for (int k = 0; k < CAP; k++) begin
            exp_q.push_back(8'hB0 + 8'(k));
            wr(16'hF010, 8'hB0 + 8'(k));
        end
        bus_idle();
        repeat (FRAME + 1 - CAP) @(negedge clock);
        exp_q.push_back(8'hC5);
        wr(16'hF010, 8'hC5);
        bus_idle();
        read_status(v);
        check("full_pop_status", v, 8'h03);
        wait_idle("full_pop_drain", (CAP + 1) * FRAME + 100);

        // Reset mid-frame: tx high at once, queued data discarded.
        @(negedge clock);
        wr(16'hF010, 8'h55);
        wr(16'hF010, 8'h5A);
        bus_idle();
        check("mid_tx_low", tx, 1'b0);
        #1 reset = 1'b1;
        exp_q.delete();
        #1;
        check("mid_reset_tx", tx, 1'b1);
        read_status(v);
        check("mid_reset_status", v, 8'h04);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        repeat (3) @(negedge clock);
        read_status(v);
        check("post_reset_status", v, 8'h04);
        check("post_reset_tx", tx, 1'b1);

        // Address decode.
        write_en = 1'b0;
        address  = 16'hF012;
        #1;
        check("dec_f012_sel", sel, 1'b0);
        check("dec_f012_data", data_out, 8'h00);
        address = 16'hF00F;
        #1;
        check("dec_f00f_sel", sel, 1'b0);
        check("dec_f00f_data", data_out, 8'h00);
        address = 16'hF010;
        #1;
        check("dec_f010_sel", sel, 1'b1);
        check("dec_f010_data", data_out, 8'h00);
        address = 16'hF011;
        #1;
        check("dec_f011_sel", sel, 1'b1);
        bus_idle();

        repeat (2) @(negedge clock);
        check("frames_outstanding", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
